// File: rtl/rfarb_pkg.sv
// Shared constants and state type for the register-file write arbiter.
package rfarb_pkg;

  localparam int unsigned REG_COUNT       = 32;
  localparam int unsigned ADDR_W          = 5;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned FIRST_CLEAR_IDX = 1;
  localparam int unsigned LAST_CLEAR_IDX  = REG_COUNT - 1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } rfarb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid bit at or above ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  int unsigned idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr) + off) % NUM_REQ;
      if (valid[IDX_W'(idx)] && !any) begin
        any                 = 1'b1;
        grant[IDX_W'(idx)]  = 1'b1;
        winner              = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register-file write port, with a zeroing sweep of x1..x31.
// Optional per-requester grant and stall counters under RFARB_STATS_EN.
module regfile_write_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned STAT_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear_req,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_rd,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  last_grant
`ifdef RFARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]   stat_grants,
  output logic [STAT_W-1:0]           stat_stalls
`endif
);

  import rfarb_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || STAT_W < 1) begin : g_param_check
    $error("regfile_write_arbiter: unsupported parameterisation");
  end

  rfarb_state_t        state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    winner;
  logic [NUM_REQ-1:0]  grant;
  logic                any_valid;
  logic                arb_en;
  logic                accept;
  logic [ADDR_W-1:0]   win_rd;
  logic [DATA_W-1:0]   win_data;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .grant  (grant),
    .winner (winner),
    .any    (any_valid)
  );

  // clear_req in IDLE pre-empts arbitration in the same cycle
  assign arb_en    = (state == IDLE) && !clear_req;
  assign req_ready = arb_en ? grant : '0;
  assign accept    = arb_en && any_valid;
  assign busy      = (state == CLEAR);

  always_comb begin
    win_rd   = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_rd   = req_rd[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      clr_cnt    <= ADDR_W'(FIRST_CLEAR_IDX);
      rr_ptr     <= '0;
      last_grant <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          rf_we    <= 1'b1;
          rf_waddr <= clr_cnt;
          rf_wdata <= '0;
          clr_cnt  <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(LAST_CLEAR_IDX))
            state <= IDLE;
        end
        IDLE: begin
          if (clear_req) begin
            rf_we    <= 1'b1;
            rf_waddr <= ADDR_W'(FIRST_CLEAR_IDX);
            rf_wdata <= '0;
            clr_cnt  <= ADDR_W'(FIRST_CLEAR_IDX + 1);
            state    <= CLEAR;
          end else if (accept) begin
            // x0 requests complete the handshake but never reach the file
            rf_we      <= (win_rd != '0);
            rf_waddr   <= win_rd;
            rf_wdata   <= win_data;
            last_grant <= winner;
            rr_ptr     <= (32'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
          end else begin
            rf_we <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

`ifdef RFARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept && grant[i] && (stat_grants[i*STAT_W +: STAT_W] != '1))
          stat_grants[i*STAT_W +: STAT_W] <= stat_grants[i*STAT_W +: STAT_W] + 1'b1;
      end
      if ((|req_valid) && !accept && (stat_stalls != '1))
        stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule
